// File: rtl/mips_pkg.sv
// Shared MIPS multiply/divide definitions: op encodings, FSM states, default width.
package mips_pkg;
  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;
endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Control-unit side handshake and HI/LO read bus of the multiply/divide unit.
interface mips_muldiv_unit_if #(parameter int WIDTH = mips_pkg::MD_WIDTH) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs, rt, input busy, done, hi, lo);
  modport slave  (input start, op, rs, rt, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_core.sv
// One-bit-per-step datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module mips_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_i,
  input  logic [WIDTH-1:0] init_lo_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
  logic [WIDTH:0]   add_sum, rem_sh;
  logic             rem_geq;

  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, opnd_i};
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_geq = rem_sh >= {1'b0, opnd_i};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (div_i) begin
      // Remainder stays below the divisor, so the difference always fits in WIDTH bits.
      hi_d = rem_geq ? (rem_sh[WIDTH-1:0] - opnd_i) : rem_sh[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], rem_geq};
    end else if (lo_q[0]) begin
      hi_d = add_sum[WIDTH:1];
      lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_d = {1'b0, hi_q[WIDTH-1:1]};
      lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (init_i) begin
      hi_q <= '0;
      lo_q <= init_lo_i;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO owner: sequences the iterative core, applies sign fix-up, handles MTHI/MTLO.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic               clk,
  input logic               reset,
  mips_muldiv_unit_if.slave md
);
  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, div_q, neg_a_q, neg_b_q, rt_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q, rs_q, opnd_q;

  logic             sgn_in, accept, start_md, step;
  logic [WIDTH-1:0] mag_rs, mag_rt, init_lo, core_hi, core_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  // Signed forms run on magnitudes; the most-negative value maps onto itself as unsigned.
  always_comb begin
    sgn_in   = (md.op == MD_MULT) || (md.op == MD_DIV);
    mag_rs   = (sgn_in && md.rs[WIDTH-1]) ? -md.rs : md.rs;
    mag_rt   = (sgn_in && md.rt[WIDTH-1]) ? -md.rt : md.rt;
    init_lo  = md.op[1] ? mag_rs : mag_rt;
    accept   = md.start && !busy_q;
    start_md = accept && !md.op[2];
    step     = state_q == MD_RUN;
  end

  mips_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .init_i    (start_md),
    .init_lo_i (init_lo),
    .step_i    (step),
    .div_i     (div_q),
    .opnd_i    (opnd_q),
    .hi_o      (core_hi),
    .lo_o      (core_lo)
  );

  always_comb begin
    prod   = {core_hi, core_lo};
    fix_hi = core_hi;
    fix_lo = core_lo;
    if (!div_q) begin
      if (neg_a_q ^ neg_b_q) prod = -prod;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (rt_zero_q) begin
      fix_hi = rs_q;
      fix_lo = '1;
    end else begin
      fix_lo = (neg_a_q ^ neg_b_q) ? -core_lo : core_lo;
      fix_hi = neg_a_q ? -core_hi : core_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      rt_zero_q <= 1'b0;
      rs_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          busy_q <= 1'b0;
          if (accept) begin
            case (md.op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                state_q   <= MD_RUN;
                busy_q    <= 1'b1;
                cnt_q     <= '0;
                div_q     <= md.op[1];
                neg_a_q   <= sgn_in && md.rs[WIDTH-1];
                neg_b_q   <= sgn_in && md.rt[WIDTH-1];
                rt_zero_q <= md.rt == '0;
                rs_q      <= md.rs;
                opnd_q    <= md.op[1] ? mag_rt : mag_rs;
              end
              MD_MTHI: begin
                hi_q   <= md.rs;
                done_q <= 1'b1;
              end
              MD_MTLO: begin
                lo_q   <= md.rs;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= MD_FIX;
        end
        MD_FIX: begin
          // busy stays up through the done cycle and drops with it on the next edge.
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule
